bingo_turn_ctrl: RTL and testbench

Turn scheduler for one Bingo board. Sequences the shared guess/circle datapath (`handle_guess_slave` and its master-side twin) by driving `cur_game_state`, `start_guess` and `clear_guess`. Counts completed lines on the local circle map after every guess and requests outgoing interboard messages (`SEL_NUM`, `STATE_WIN`) through a ready/valid send port. Sits between the top-level game FSM and the guess datapath, one instance per board.

---
 rtl/bingo_turn_ctrl_pkg.sv | 57 +++++
 rtl/bingo_turn_ctrl_line_counter.sv | 26 ++
 rtl/bingo_turn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bingo_turn_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bingo_turn_ctrl_pkg.sv
// Shared definitions for the Bingo turn scheduler and the guess datapath:
// game state codes, interboard message types and the 12 winning-line masks.
package bingo_turn_ctrl_pkg;

   // The guess datapath keys on codes 4..7, so the encoding is fixed.
   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_CLEAR         = 4'd1,
      ST_P1_GUESS      = 4'd4,
      ST_WAIT_P1_GUESS = 4'd5,
      ST_WAIT_P2_GUESS = 4'd6,
      ST_P2_GUESS      = 4'd7,
      ST_SEND_SEL      = 4'd8,
      ST_CHECK         = 4'd9,
      ST_SEND_WIN      = 4'd10,
      ST_WIN           = 4'd11,
      ST_LOSE          = 4'd12
   } game_state_e;

   // Interboard message types.
   localparam logic [2:0] MSG_NONE      = 3'd0;
   localparam logic [2:0] MSG_SEL_NUM   = 3'd1;
   localparam logic [2:0] MSG_STATE_WIN = 3'd2;

   // Board positions are row-major: position = 5*row + col.
   localparam int NUM_LINES = 12;
   localparam logic [NUM_LINES-1:0][24:0] LINE_MASKS = {
      25'h0111110,   // anti-diagonal (4,8,12,16,20)
      25'h1041041,   // main diagonal (0,6,12,18,24)
      25'h1084210,   // column 4
      25'h0842108,   // column 3
      25'h0421084,   // column 2
      25'h0210842,   // column 1
      25'h0108421,   // column 0
      25'h1F00000,   // row 4
      25'h00F8000,   // row 3
      25'h0007C00,   // row 2
      25'h00003E0,   // row 1
      25'h000001F    // row 0
   };

   // Turn in which this board makes the guess.
   function automatic game_state_e local_turn(input logic master);
      return master ? ST_P1_GUESS : ST_P2_GUESS;
   endfunction

   // Turn in which the peer board makes the guess.
   function automatic game_state_e remote_turn(input logic master);
      return master ? ST_WAIT_P2_GUESS : ST_WAIT_P1_GUESS;
   endfunction

   function automatic logic is_turn_state(input game_state_e s);
      return (s == ST_P1_GUESS) || (s == ST_WAIT_P1_GUESS) ||
             (s == ST_WAIT_P2_GUESS) || (s == ST_P2_GUESS);
   endfunction

endpackage

// File: rtl/bingo_turn_ctrl_line_counter.sv
// Combinational count of fully circled lines (rows, columns, diagonals).
module bingo_line_counter
   import bingo_turn_ctrl_pkg::*;
(
   input  logic [24:0] i_circle,
   output logic [3:0]  o_count
);

   logic [NUM_LINES-1:0] w_line_full;

   // A line is complete when every position under its mask is circled.
   generate
      for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
         assign w_line_full[gi] = &(i_circle | ~LINE_MASKS[gi]);
      end
   endgenerate

   // Population count of complete lines.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         o_count = o_count + 4'(w_line_full[i]);
      end
   end

endmodule

// File: rtl/bingo_turn_ctrl.sv
// Turn scheduler for one Bingo board: drives the guess datapath state code,
// start/clear pulses, counts completed lines and requests SEL_NUM / STATE_WIN
// messages. Optional macro GAME_AUTO_RESTART_EN adds a timed return from
// WIN/LOSE to IDLE after RESTART_CYCLES cycles.
module bingo_turn_ctrl
   import bingo_turn_ctrl_pkg::*;
#(
   parameter int LINES_TO_WIN   = 5,
   parameter int RESTART_CYCLES = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interboard_rst,
   input  logic        new_game,
   input  logic        is_master,
   input  logic        guess_done,
   input  logic [24:0] circle,
   input  logic        interboard_en,
   input  logic [2:0]  interboard_msg_type,
   input  logic        send_ready,
   output logic [3:0]  cur_game_state,
   output logic        start_guess,
   output logic        clear_guess,
   output logic        send_req,
   output logic [2:0]  send_msg_type,
   output logic [3:0]  line_count,
   output logic        win,
   output logic        lose
);

   game_state_e r_state;
   logic        r_master;
   logic        r_from_local;
   logic        r_start_guess;
   logic        r_clear_guess;
   logic        r_send_req;
   logic [2:0]  r_send_msg_type;
   logic [3:0]  r_line_count;
   logic        r_win;
   logic        r_lose;

   logic [3:0]  w_count;
   logic        w_reached;
   logic        w_peer_win;
   logic        w_can_lose;
   logic        w_restart_due;
   game_state_e w_local_turn;
   game_state_e w_remote_turn;

   bingo_line_counter u_line_counter (
      .i_circle (circle),
      .o_count  (w_count)
   );

   assign w_reached     = int'(w_count) >= LINES_TO_WIN;
   assign w_peer_win    = interboard_en && (interboard_msg_type == MSG_STATE_WIN);
   assign w_can_lose    = is_turn_state(r_state) || (r_state == ST_SEND_SEL) ||
                          (r_state == ST_CHECK);
   assign w_local_turn  = local_turn(r_master);
   assign w_remote_turn = remote_turn(r_master);

`ifdef GAME_AUTO_RESTART_EN
   localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
   logic [CNT_W-1:0] r_restart_cnt;
   logic             w_in_end;

   assign w_in_end      = (r_state == ST_WIN) || (r_state == ST_LOSE);
   assign w_restart_due = w_in_end && (r_restart_cnt == CNT_W'(RESTART_CYCLES - 1));

   // Cycles spent in WIN/LOSE; held at zero everywhere else.
   always_ff @(posedge clk) begin
      if (rst || interboard_rst || !w_in_end || w_restart_due) begin
         r_restart_cnt <= '0;
      end else begin
         r_restart_cnt <= r_restart_cnt + 1'b1;
      end
   end
`else
   logic [31:0] w_unused_restart;
   assign w_unused_restart = 32'(RESTART_CYCLES);
   assign w_restart_due    = 1'b0;
`endif

   // Game sequencing: state, turn bookkeeping and every registered output.
   always_ff @(posedge clk) begin
      if (rst || interboard_rst) begin
         r_state         <= ST_IDLE;
         r_master        <= 1'b0;
         r_from_local    <= 1'b0;
         r_start_guess   <= 1'b0;
         r_clear_guess   <= 1'b0;
         r_send_req      <= 1'b0;
         r_send_msg_type <= MSG_NONE;
         r_line_count    <= '0;
         r_win           <= 1'b0;
         r_lose          <= 1'b0;
      end else begin
         r_start_guess <= 1'b0;
         r_clear_guess <= 1'b0;
         if (r_state == ST_CHECK) begin
            r_line_count <= w_count;
         end
         // A peer win overrides whatever this board would do this cycle.
         if (w_peer_win && w_can_lose) begin
            r_state    <= ST_LOSE;
            r_lose     <= 1'b1;
            r_send_req <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (new_game) begin
                     r_master      <= is_master;
                     r_state       <= ST_CLEAR;
                     r_clear_guess <= 1'b1;
                  end
               end
               ST_CLEAR: begin
                  r_state       <= r_master ? w_local_turn : w_remote_turn;
                  r_start_guess <= 1'b1;
               end
               ST_P1_GUESS, ST_WAIT_P1_GUESS, ST_WAIT_P2_GUESS, ST_P2_GUESS: begin
                  if (guess_done) begin
                     r_from_local <= (r_state == w_local_turn);
                     if (r_state == w_local_turn) begin
                        r_state         <= ST_SEND_SEL;
                        r_send_req      <= 1'b1;
                        r_send_msg_type <= MSG_SEL_NUM;
                     end else begin
                        r_state <= ST_CHECK;
                     end
                  end
               end
               ST_SEND_SEL: begin
                  if (send_ready) begin
                     r_state    <= ST_CHECK;
                     r_send_req <= 1'b0;
                  end
               end
               ST_CHECK: begin
                  if (w_reached) begin
                     r_state         <= ST_SEND_WIN;
                     r_send_req      <= 1'b1;
                     r_send_msg_type <= MSG_STATE_WIN;
                  end else begin
                     r_state       <= r_from_local ? w_remote_turn : w_local_turn;
                     r_start_guess <= 1'b1;
                  end
               end
               ST_SEND_WIN: begin
                  if (send_ready) begin
                     r_state    <= ST_WIN;
                     r_win      <= 1'b1;
                     r_send_req <= 1'b0;
                  end
               end
               ST_WIN, ST_LOSE: begin
                  if (w_restart_due) begin
                     r_state <= ST_IDLE;
                     r_win   <= 1'b0;
                     r_lose  <= 1'b0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign cur_game_state = r_state;
   assign start_guess    = r_start_guess;
   assign clear_guess    = r_clear_guess;
   assign send_req       = r_send_req;
   assign send_msg_type  = r_send_msg_type;
   assign line_count     = r_line_count;
   assign win            = r_win;
   assign lose           = r_lose;

endmodule

// File: tb/tb_bingo_turn_ctrl.sv
// Scoreboard bench for bingo_turn_ctrl: a driver plays directed and random
// games and queues the expected observable events; a monitor pops them as
// the DUT produces them. Honours GAME_AUTO_RESTART_EN when defined.
module tb_bingo_turn_ctrl;
   import bingo_turn_ctrl_pkg::*;

   localparam int LTW = 5;
   localparam int RC  = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        interboard_rst = 1'b0;
   logic        new_game = 1'b0;
   logic        is_master = 1'b0;
   logic        guess_done = 1'b0;
   logic [24:0] circle = '0;
   logic        interboard_en = 1'b0;
   logic [2:0]  interboard_msg_type = '0;
   logic        send_ready = 1'b0;
   logic [3:0]  cur_game_state;
   logic        start_guess;
   logic        clear_guess;
   logic        send_req;
   logic [2:0]  send_msg_type;
   logic [3:0]  line_count;
   logic        win;
   logic        lose;

   always #5 clk = ~clk;

   bingo_turn_ctrl #(.LINES_TO_WIN(LTW), .RESTART_CYCLES(RC)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .interboard_rst      (interboard_rst),
      .new_game            (new_game),
      .is_master           (is_master),
      .guess_done          (guess_done),
      .circle              (circle),
      .interboard_en       (interboard_en),
      .interboard_msg_type (interboard_msg_type),
      .send_ready          (send_ready),
      .cur_game_state      (cur_game_state),
      .start_guess         (start_guess),
      .clear_guess         (clear_guess),
      .send_req            (send_req),
      .send_msg_type       (send_msg_type),
      .line_count          (line_count),
      .win                 (win),
      .lose                (lose)
   );

   localparam int EV_CLEAR = 0, EV_START = 1, EV_SEND = 2, EV_LINES = 3, EV_END = 4;
   typedef struct { int kind; int val; } ev_t;
   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic string kname(input int k);
      case (k)
         EV_CLEAR: return "clear";
         EV_START: return "start";
         EV_SEND:  return "send";
         EV_LINES: return "lines";
         default:  return "end";
      endcase
   endfunction

   function automatic void push(input int k, input int v);
      exp_q.push_back('{kind: k, val: v});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference line count computed straight from the board geometry.
   function automatic int ref_lines(input logic [24:0] m);
      int  n = 0;
      bit  full;
      for (int r = 0; r < 5; r++) begin
         full = 1;
         for (int c = 0; c < 5; c++) if (!m[5*r+c]) full = 0;
         n += int'(full);
      end
      for (int c = 0; c < 5; c++) begin
         full = 1;
         for (int r = 0; r < 5; r++) if (!m[5*r+c]) full = 0;
         n += int'(full);
      end
      full = 1;
      for (int k = 0; k < 5; k++) if (!m[6*k]) full = 0;
      n += int'(full);
      full = 1;
      for (int k = 0; k < 5; k++) if (!m[4*k+4]) full = 0;
      n += int'(full);
      return n;
   endfunction

   function automatic int exp_turn(input bit master, input bit loc);
      if (loc) return master ? 4 : 7;
      return master ? 6 : 5;
   endfunction

   // ---------------- monitor ----------------
   logic [3:0] mon_prev_state = '0;
   logic       mon_prev_win = 1'b0, mon_prev_lose = 1'b0;
   logic       mon_prev_pend = 1'b0, mon_prev_rst = 1'b0;
   logic [2:0] mon_prev_type = '0;

   task automatic observe(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got %0d, required no event", kname(kind), val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            errors++;
            $display("FAIL event_order: got %s=%0d, required %s=%0d",
                     kname(kind), val, kname(e.kind), e.val);
         end else begin
            $display("txn %s=%0d @%0t", kname(kind), val, $time);
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_prev_state == 4'd9 && !mon_prev_rst && cur_game_state != 4'd12)
            observe(EV_LINES, int'(line_count));
         if (clear_guess) observe(EV_CLEAR, 0);
         if (start_guess) observe(EV_START, int'(cur_game_state));
         if (mon_prev_pend && !mon_prev_rst && cur_game_state != 4'd12)
            check("send_req_held", {28'd0, send_req, send_msg_type}, {28'd0, 1'b1, mon_prev_type});
         if (send_req && send_ready) observe(EV_SEND, int'(send_msg_type));
         if ((win && !mon_prev_win) || (lose && !mon_prev_lose))
            observe(EV_END, int'(cur_game_state));
         mon_prev_state = cur_game_state;
         mon_prev_win   = win;
         mon_prev_lose  = lose;
         mon_prev_pend  = send_req && !send_ready;
         mon_prev_type  = send_msg_type;
         mon_prev_rst   = rst || interboard_rst;
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = start_guess, 1 = send_req, 2 = win or lose
   task automatic wait_for(input int which, input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if ((which == 0 && start_guess) || (which == 1 && send_req) ||
             (which == 2 && (win || lose))) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got no event in 50 cycles, required event", name);
      end
   endtask

   task automatic do_accept(input int delay);
      bit ok;
      wait_for(1, "send_req", ok);
      if (!ok) return;
      repeat (delay) tick();
      send_ready = 1'b1;
      tick();
      send_ready = 1'b0;
      check("send_req_drop", {31'd0, send_req}, 32'd0);
   endtask

   task automatic reset_and_check(input bit use_peer);
      if (use_peer) interboard_rst = 1'b1; else rst = 1'b1;
      tick();
      interboard_rst = 1'b0;
      rst = 1'b0;
      check("reset_outputs", {19'd0, cur_game_state, line_count, start_guess, clear_guess,
                              send_req, win, lose}, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic finish_game(input logic [3:0] end_state);
      bit ok;
      int n;
      bit bad_req;
      wait_for(2, "end", ok);
      if (ok) begin
         check("end_state", {28'd0, cur_game_state}, {28'd0, end_state});
         check("win_lose_level", {30'd0, win, lose}, (end_state == 4'd11) ? 32'd2 : 32'd1);
         n = 1;
         bad_req = 0;
         for (int i = 0; i < 30; i++) begin
            new_game = (i == 2);
            tick();
            new_game = 1'b0;
            if (cur_game_state == end_state) begin
               n++;
               bad_req |= send_req;
            end else begin
               break;
            end
         end
         check("no_send_in_end", {31'd0, bad_req}, 32'd0);
`ifdef GAME_AUTO_RESTART_EN
         check("restart_len", n, RC);
         check("after_restart", {28'd0, cur_game_state}, 32'd0);
`else
         check("terminal_hold", n, 31);
`endif
      end
      reset_and_check(0);
   endtask

   // mode 0: random, 1: rows then full board, 2: peer reset in SEND_SEL,
   // 3: peer win arriving in a CHECK that would otherwise win
   task automatic play(input bit master, input int mode);
      bit          loc = master;
      bit          ok;
      int          n;
      logic [24:0] map = '0;
      repeat ($urandom_range(1, 3)) tick();
      is_master = master;
      new_game  = 1'b1;
      push(EV_CLEAR, 0);
      push(EV_START, exp_turn(master, loc));
      tick();
      new_game  = 1'b0;
      is_master = ~master;
      for (int t = 0; t < 80; t++) begin
         wait_for(0, "start_guess", ok);
         if (!ok) begin
            reset_and_check(0);
            return;
         end
         repeat ($urandom_range(0, 2)) tick();
         if (mode == 0 && $urandom_range(0, 3) == 0) begin
            interboard_en = 1'b1;
            interboard_msg_type = MSG_SEL_NUM;
            tick();
            interboard_en = 1'b0;
         end
         if (mode == 0 && t > 0 && $urandom_range(0, 9) == 0) begin
            interboard_en = 1'b1;
            interboard_msg_type = MSG_STATE_WIN;
            push(EV_END, 12);
            tick();
            interboard_en = 1'b0;
            finish_game(4'd12);
            return;
         end
         case (mode)
            1: map = (t == 0) ? 25'h00FFFFF : 25'h1FFFFFF;
            3: map = 25'h1FFFFFF;
            default: begin
               map[$urandom_range(0, 24)] = 1'b1;
               map[$urandom_range(0, 24)] = 1'b1;
            end
         endcase
         circle = map;
         guess_done = 1'b1;
         tick();
         guess_done = 1'b0;
         if (loc) begin
            check("local_guess_to_send_sel", {25'd0, cur_game_state, send_msg_type},
                  {25'd0, 4'd8, MSG_SEL_NUM});
            if (mode == 2) begin
               reset_and_check(1);
               return;
            end
            push(EV_SEND, int'(MSG_SEL_NUM));
            do_accept($urandom_range(0, 3));
         end else begin
            check("remote_guess_to_check", {28'd0, cur_game_state}, 32'd9);
            if (mode == 3) begin
               interboard_en = 1'b1;
               interboard_msg_type = MSG_STATE_WIN;
               push(EV_END, 12);
               tick();
               interboard_en = 1'b0;
               finish_game(4'd12);
               return;
            end
         end
         n = ref_lines(map);
         push(EV_LINES, n);
         if (n >= LTW) begin
            push(EV_SEND, int'(MSG_STATE_WIN));
            push(EV_END, 11);
            do_accept((mode == 1) ? 3 : $urandom_range(0, 3));
            finish_game(4'd11);
            return;
         end
         loc = !loc;
         push(EV_START, exp_turn(master, loc));
      end
      repeat (3) tick();
      reset_and_check(0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got no finish, required finish within 5 ms");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      repeat (3) tick();
      rst = 1'b0;
      check("reset_outputs_init", {19'd0, cur_game_state, line_count, start_guess, clear_guess,
                                   send_req, win, lose}, 32'd0);
      guess_done = 1'b1;
      tick();
      guess_done = 1'b0;
      tick();
      check("guess_in_idle_ignored", {28'd0, cur_game_state}, 32'd0);

      play(1, 1);
      play(0, 0);
      play(1, 2);
      play(0, 3);
      for (int g = 0; g < 10; g++) play(1'($urandom_range(0, 1)), 0);

      repeat (5) tick();
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
